// File: rtl/lru_update_array_if.sv
// Access/flush port bundle between the cache controller and the per-set pLRU store.
// master = controller side, slave = lru_update_array.
interface lru_update_array_if #(
  parameter int unsigned IDX_W = 3
);
  logic [IDX_W-1:0] rd_index;
  logic [2:0]       rd_lru;
  logic             upd_valid;
  logic [IDX_W-1:0] upd_index;
  logic [1:0]       upd_way;
  logic             flush_req;
  logic             busy;
  logic             flush_done;

  modport master (
    output rd_index, upd_valid, upd_index, upd_way, flush_req,
    input  rd_lru, busy, flush_done
  );

  modport slave (
    input  rd_index, upd_valid, upd_index, upd_way, flush_req,
    output rd_lru, busy, flush_done
  );
endinterface

// File: rtl/lru_update_array.sv
// Per-set 3-bit tree pLRU storage for a 4-way cache, with hit/fill updates
// and a one-set-per-cycle flush sweep.
module lru_update_array #(
  parameter int unsigned NUM_SETS = 8,
  parameter int unsigned IDX_W    = $clog2(NUM_SETS)
) (
  input logic              clk,
  input logic              rst_n,
  lru_update_array_if.slave bus
);

  typedef enum logic [0:0] {StIdle, StFlush} state_e;

  localparam logic [IDX_W-1:0] LastIdx = IDX_W'(NUM_SETS - 1);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;
  logic             flush_done_q, flush_done_d;
  logic [2:0]       lru_q [NUM_SETS];

  logic             wr_en;
  logic [IDX_W-1:0] wr_idx;
  logic [2:0]       wr_val;
  logic [2:0]       cur_lru;
  logic [2:0]       upd_val;

  // Bit 2 points away from the touched pair; the pair's own bit points at its
  // untouched member. The other pair's bit is preserved.
  always_comb begin
    cur_lru = lru_q[bus.upd_index];
    upd_val = cur_lru;
    unique case (bus.upd_way)
      2'b00: upd_val = {2'b00, cur_lru[0]};
      2'b01: upd_val = {2'b01, cur_lru[0]};
      2'b10: upd_val = {1'b1, cur_lru[1], 1'b0};
      2'b11: upd_val = {1'b1, cur_lru[1], 1'b1};
    endcase
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    flush_done_d = 1'b0;
    wr_en        = 1'b0;
    wr_idx       = bus.upd_index;
    wr_val       = upd_val;
    case (state_q)
      StIdle: begin
        wr_en = bus.upd_valid;
        if (bus.flush_req) begin
          state_d = StFlush;
          cnt_d   = '0;
        end
      end
      StFlush: begin
        // Updates and new flush requests are dropped for the whole sweep.
        wr_en  = 1'b1;
        wr_idx = cnt_q;
        wr_val = 3'b000;
        if (cnt_q == LastIdx) begin
          state_d      = StIdle;
          cnt_d        = '0;
          flush_done_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      flush_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      flush_done_q <= flush_done_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_SETS; i++) begin
        lru_q[i] <= 3'b000;
      end
    end else begin
      for (int unsigned i = 0; i < NUM_SETS; i++) begin
        if (wr_en && (wr_idx == IDX_W'(i))) begin
          lru_q[i] <= wr_val;
        end
      end
    end
  end

  // No write bypass: readers see the entry as stored before this edge.
  assign bus.rd_lru     = lru_q[bus.rd_index];
  assign bus.busy       = (state_q == StFlush);
  assign bus.flush_done = flush_done_q;

endmodule
